// File: rtl/gb_interposer_nway.sv
// Ghostbus interposer: one host GBPORT bus fanned out to NCH child windows of 2**SUB_AW words.
// Registered request stage, fixed-latency read FSM, saturating error counters.
module gb_interposer_nway #(
   parameter int unsigned AW     = 24,
   parameter int unsigned DW     = 32,
   parameter int unsigned NCH    = 4,
   parameter int unsigned SUB_AW = 20,
   parameter int unsigned RD_LAT = 1,
   parameter logic [DW-1:0] DEF_RD = DW'(32'hDEADBEEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     GBPORT_addr,
   input  logic [DW-1:0]     GBPORT_dout,
   output logic [DW-1:0]     GBPORT_din,
   input  logic              GBPORT_we,
   input  logic              GBPORT_wstb,
   input  logic              GBPORT_rstb,
   output logic              rvalid,
   output logic [SUB_AW-1:0] ch_addr,
   output logic [DW-1:0]     ch_dout,
   output logic              ch_we,
   output logic [NCH-1:0]    ch_wstb,
   output logic [NCH-1:0]    ch_rstb,
   input  logic [NCH*DW-1:0] ch_din,
   output logic [7:0]        err_unmap,
   output logic [7:0]        err_drop
);

   localparam int unsigned CB   = $clog2(NCH);
   localparam int unsigned CHW  = (CB == 0) ? 1 : CB;
   localparam int unsigned CNTW = 4;

   typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_t;

   state_t          state;
   logic [CNTW-1:0] cnt;
   logic [CHW-1:0]  rd_ch;
   logic            rd_hit;

   // Reset asserts immediately, releases two clocks after rst falls
   logic [1:0] rst_pipe;
   logic       rst_int;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_pipe <= 2'b11;
      else     rst_pipe <= {rst_pipe[0], 1'b0};
   end

   assign rst_int = rst_pipe[1];

   // Channel decode; shifts keep NCH=1 (zero channel bits) legal
   logic [AW-1:0]  addr_sh;
   logic [AW-1:0]  addr_up;
   logic [CHW-1:0] dec_ch;
   logic           dec_hit;
   logic [NCH-1:0] dec_oh;
   logic           wr_ev;
   logic           rd_acc;
   logic           rd_drop;
   logic           unmap_inc;

   always_comb begin
      addr_sh   = GBPORT_addr >> SUB_AW;
      addr_up   = GBPORT_addr >> (SUB_AW + CB);
      dec_ch    = CHW'(addr_sh & AW'((64'd1 << CB) - 64'd1));
      dec_hit   = (addr_up == '0) && (32'(dec_ch) < NCH);
      dec_oh    = NCH'(1) << dec_ch;
      wr_ev     = GBPORT_wstb & GBPORT_we;
      rd_acc    = GBPORT_rstb && !wr_ev && (state == IDLE);
      rd_drop   = GBPORT_rstb && !rd_acc;
      unmap_inc = (wr_ev || rd_acc) && !dec_hit;
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state      <= IDLE;
         cnt        <= '0;
         rd_ch      <= '0;
         rd_hit     <= 1'b0;
         GBPORT_din <= '0;
         rvalid     <= 1'b0;
         ch_addr    <= '0;
         ch_dout    <= '0;
         ch_we      <= 1'b0;
         ch_wstb    <= '0;
         ch_rstb    <= '0;
         err_unmap  <= '0;
         err_drop   <= '0;
      end else begin
         ch_wstb <= '0;
         ch_rstb <= '0;
         rvalid  <= 1'b0;

         // A dropped read never disturbs the address seen by an in-flight child read
         if (wr_ev || rd_acc) begin
            ch_addr <= GBPORT_addr[SUB_AW-1:0];
            ch_dout <= GBPORT_dout;
            ch_we   <= wr_ev;
         end
         if (wr_ev && dec_hit)  ch_wstb <= dec_oh;
         if (rd_acc && dec_hit) ch_rstb <= dec_oh;

         case (state)
            IDLE: begin
               if (rd_acc) begin
                  rd_ch  <= dec_ch;
                  rd_hit <= dec_hit;
                  cnt    <= CNTW'(RD_LAT);
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == CNTW'(1)) state <= CAPT;
               else                 cnt   <= cnt - CNTW'(1);
            end
            CAPT: begin
               GBPORT_din <= rd_hit ? ch_din[32'(rd_ch) * DW +: DW] : DEF_RD;
               rvalid     <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (unmap_inc && (err_unmap != 8'hFF)) err_unmap <= err_unmap + 8'd1;
         if (rd_drop && (err_drop != 8'hFF))    err_drop  <= err_drop + 8'd1;
      end
   end

endmodule

// File: tb/tb_gb_interposer_nway.sv
// Bench for gb_interposer_nway: directed tests on a 4-channel instance plus a
// random sweep over 1/3/16-channel instances, read data checked through scoreboards.
module tb_gb_interposer_nway;

   localparam int unsigned RD_LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Main 4-channel instance
   logic [23:0]  m_addr = '0;
   logic [31:0]  m_dout = '0;
   logic         m_we = 1'b0, m_wstb = 1'b0, m_rstb = 1'b0;
   logic [31:0]  m_gdin;
   logic         m_rvalid;
   logic [19:0]  m_caddr;
   logic [31:0]  m_cdout;
   logic         m_cwe;
   logic [3:0]   m_cwstb, m_crstb;
   logic [127:0] m_din = '0;
   logic [7:0]   m_unmap, m_drop;

   gb_interposer_nway #(.AW(24), .DW(32), .NCH(4), .SUB_AW(20), .RD_LAT(RD_LAT),
                        .DEF_RD(32'hDEADBEEF)) u_main (
      .clk(clk), .rst(rst), .GBPORT_addr(m_addr), .GBPORT_dout(m_dout),
      .GBPORT_din(m_gdin), .GBPORT_we(m_we), .GBPORT_wstb(m_wstb), .GBPORT_rstb(m_rstb),
      .rvalid(m_rvalid), .ch_addr(m_caddr), .ch_dout(m_cdout), .ch_we(m_cwe),
      .ch_wstb(m_cwstb), .ch_rstb(m_crstb), .ch_din(m_din),
      .err_unmap(m_unmap), .err_drop(m_drop));

   // Sweep instances share one host bus
   logic [23:0]  s_addr = '0;
   logic [31:0]  s_dout = '0;
   logic         s_we = 1'b0, s_wstb = 1'b0, s_rstb = 1'b0;
   logic [31:0]  s1_gdin, s3_gdin, s16_gdin;
   logic         s1_rv, s3_rv, s16_rv;
   logic [19:0]  s1_caddr, s3_caddr, s16_caddr;
   logic [31:0]  s1_cdout, s3_cdout, s16_cdout;
   logic         s1_cwe, s3_cwe, s16_cwe;
   logic [0:0]   s1_wstb, s1_rstb;
   logic [2:0]   s3_wstb, s3_rstb;
   logic [15:0]  s16_wstb, s16_rstb;
   logic [31:0]  s1_din = '0;
   logic [95:0]  s3_din = '0;
   logic [511:0] s16_din = '0;
   logic [7:0]   s1_unmap, s3_unmap, s16_unmap, s1_drop, s3_drop, s16_drop;

   gb_interposer_nway #(.AW(24), .DW(32), .NCH(1), .SUB_AW(20), .RD_LAT(1),
                        .DEF_RD(32'hDEADBEEF)) u_s1 (
      .clk(clk), .rst(rst), .GBPORT_addr(s_addr), .GBPORT_dout(s_dout),
      .GBPORT_din(s1_gdin), .GBPORT_we(s_we), .GBPORT_wstb(s_wstb), .GBPORT_rstb(s_rstb),
      .rvalid(s1_rv), .ch_addr(s1_caddr), .ch_dout(s1_cdout), .ch_we(s1_cwe),
      .ch_wstb(s1_wstb), .ch_rstb(s1_rstb), .ch_din(s1_din),
      .err_unmap(s1_unmap), .err_drop(s1_drop));

   gb_interposer_nway #(.AW(24), .DW(32), .NCH(3), .SUB_AW(20), .RD_LAT(2),
                        .DEF_RD(32'hDEADBEEF)) u_s3 (
      .clk(clk), .rst(rst), .GBPORT_addr(s_addr), .GBPORT_dout(s_dout),
      .GBPORT_din(s3_gdin), .GBPORT_we(s_we), .GBPORT_wstb(s_wstb), .GBPORT_rstb(s_rstb),
      .rvalid(s3_rv), .ch_addr(s3_caddr), .ch_dout(s3_cdout), .ch_we(s3_cwe),
      .ch_wstb(s3_wstb), .ch_rstb(s3_rstb), .ch_din(s3_din),
      .err_unmap(s3_unmap), .err_drop(s3_drop));

   gb_interposer_nway #(.AW(24), .DW(32), .NCH(16), .SUB_AW(20), .RD_LAT(5),
                        .DEF_RD(32'hDEADBEEF)) u_s16 (
      .clk(clk), .rst(rst), .GBPORT_addr(s_addr), .GBPORT_dout(s_dout),
      .GBPORT_din(s16_gdin), .GBPORT_we(s_we), .GBPORT_wstb(s_wstb), .GBPORT_rstb(s_rstb),
      .rvalid(s16_rv), .ch_addr(s16_caddr), .ch_dout(s16_cdout), .ch_we(s16_cwe),
      .ch_wstb(s16_wstb), .ch_rstb(s16_rstb), .ch_din(s16_din),
      .err_unmap(s16_unmap), .err_drop(s16_drop));

   logic [15:0] sw_wstb [3];
   logic [15:0] sw_rstb [3];
   logic        sw_rv   [3];
   logic [31:0] sw_gdin [3];
   logic [7:0]  sw_unmap[3];
   assign sw_wstb[0] = 16'(s1_wstb);  assign sw_wstb[1] = 16'(s3_wstb);  assign sw_wstb[2] = s16_wstb;
   assign sw_rstb[0] = 16'(s1_rstb);  assign sw_rstb[1] = 16'(s3_rstb);  assign sw_rstb[2] = s16_rstb;
   assign sw_rv[0]   = s1_rv;         assign sw_rv[1]   = s3_rv;         assign sw_rv[2]   = s16_rv;
   assign sw_gdin[0] = s1_gdin;       assign sw_gdin[1] = s3_gdin;       assign sw_gdin[2] = s16_gdin;
   assign sw_unmap[0] = s1_unmap;     assign sw_unmap[1] = s3_unmap;     assign sw_unmap[2] = s16_unmap;

   typedef struct {int d; logic [31:0] data;} sexp_t;
   logic [31:0] mq[$];
   sexp_t       sq[$];

   function automatic int nch_of(int d);
      return (d == 0) ? 1 : (d == 1) ? 3 : 16;
   endfunction

   function automatic int lat_of(int d);
      return (d == 0) ? 1 : (d == 1) ? 2 : 5;
   endfunction

   function automatic logic [31:0] chdata(int d, int i);
      return 32'hD000_0000 | 32'(d << 20) | 32'(i * 32'h111);
   endfunction

   // One-cycle host strobe on the main bus; entered and left at posedge+1
   task automatic drive(input logic [23:0] a, input logic [31:0] d,
                        input logic we, input logic ws, input logic rs);
      m_addr = a; m_dout = d; m_we = we; m_wstb = ws; m_rstb = rs;
      @(posedge clk); #1;
      m_we = 1'b0; m_wstb = 1'b0; m_rstb = 1'b0;
   endtask

   // Bounded wait for rvalid on the main bus; n=0 on timeout
   task automatic wait_rvalid(output int n, output logic [31:0] d);
      n = 0; d = '0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (m_rvalid) begin n = i; d = m_gdin; return; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({m_gdin, m_rvalid, m_caddr, m_cdout, m_cwe} !== '0) begin
         bad++; $display("FAIL reset_data: got %h want 0", {m_gdin, m_rvalid, m_caddr, m_cdout, m_cwe});
      end
      total++;
      if ({m_cwstb, m_crstb} !== 8'h00) begin
         bad++; $display("FAIL reset_strobes: got %h want 00", {m_cwstb, m_crstb});
      end
      total++;
      if ({m_unmap, m_drop} !== 16'h0000) begin
         bad++; $display("FAIL reset_counters: got %h want 0000", {m_unmap, m_drop});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_write();
      drive(24'h200010, 32'h0000_1234, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (m_cwstb !== 4'b0100) begin bad++; $display("FAIL wr_strobe: got %b want 0100", m_cwstb); end
      total++;
      if (m_caddr !== 20'h00010) begin bad++; $display("FAIL wr_addr: got %h want 00010", m_caddr); end
      total++;
      if ({m_cdout, m_cwe, m_crstb} !== {32'h0000_1234, 1'b1, 4'b0000}) begin
         bad++; $display("FAIL wr_data_we: got %h want %h", {m_cdout, m_cwe, m_crstb}, {32'h1234, 1'b1, 4'b0});
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (m_cwstb !== 4'b0000) begin bad++; $display("FAIL wr_single_cycle: got %b want 0000", m_cwstb); end
      @(posedge clk); #1;
      drive(24'h100000, 32'h0000_9999, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if ({m_cwstb, m_cdout} !== {4'b0000, 32'h0000_1234}) begin
         bad++; $display("FAIL wstb_no_we: got %h want %h", {m_cwstb, m_cdout}, {4'b0, 32'h1234});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      int n;
      logic [31:0] d, exp;
      m_din[3*32 +: 32] = 32'hCAFE_0001;
      mq.push_back(32'hCAFE_0001);
      drive(24'h300004, 32'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      total++;
      if ({m_crstb, m_caddr, m_cwe} !== {4'b1000, 20'h00004, 1'b0}) begin
         bad++; $display("FAIL rd_strobe: got %h want %h", {m_crstb, m_caddr, m_cwe}, {4'b1000, 20'h4, 1'b0});
      end
      wait_rvalid(n, d);
      total++;
      if (n + 1 !== RD_LAT + 2) begin bad++; $display("FAIL rd_latency: got %0d want %0d", n + 1, RD_LAT + 2); end
      exp = (mq.size() > 0) ? mq.pop_front() : 32'h0;
      total++;
      if (d !== exp) begin bad++; $display("FAIL rd_data: got %h want %h", d, exp); end
      @(negedge clk);
      total++;
      if ({m_rvalid, m_gdin} !== {1'b0, 32'hCAFE_0001}) begin
         bad++; $display("FAIL rd_hold: got %h want %h", {m_rvalid, m_gdin}, {1'b0, 32'hCAFE0001});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_unmapped();
      logic [23:0] ta[3] = '{24'h800000, 24'h3FFFFF, 24'h400000};
      logic [3:0]  tr[3] = '{4'b0000, 4'b1000, 4'b0000};
      logic [31:0] td[3] = '{32'hDEADBEEF, 32'hCAFE0001, 32'hDEADBEEF};
      logic [7:0]  tu[3] = '{8'd1, 8'd1, 8'd2};
      int n;
      logic [31:0] d, exp;
      for (int i = 0; i < 3; i++) begin
         mq.push_back(td[i]);
         drive(ta[i], 32'h0, 1'b0, 1'b0, 1'b1);
         @(negedge clk);
         total++;
         if (m_crstb !== tr[i]) begin bad++; $display("FAIL unm_strobe[%0d]: got %b want %b", i, m_crstb, tr[i]); end
         wait_rvalid(n, d);
         total++;
         if (n + 1 !== RD_LAT + 2) begin bad++; $display("FAIL unm_latency[%0d]: got %0d want %0d", i, n + 1, RD_LAT + 2); end
         exp = (mq.size() > 0) ? mq.pop_front() : 32'h0;
         total++;
         if (d !== exp) begin bad++; $display("FAIL unm_data[%0d]: got %h want %h", i, d, exp); end
         total++;
         if (m_unmap !== tu[i]) begin bad++; $display("FAIL unm_count[%0d]: got %0d want %0d", i, m_unmap, tu[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_drop();
      int n;
      logic [31:0] d, exp;
      m_din[1*32 +: 32] = 32'h1111_1111;
      mq.push_back(32'h1111_1111);
      m_addr = 24'h100000; m_rstb = 1'b1;
      @(posedge clk); #1;
      m_addr = 24'h200000;
      @(negedge clk);
      total++;
      if (m_crstb !== 4'b0010) begin bad++; $display("FAIL drop_first: got %b want 0010", m_crstb); end
      @(posedge clk); #1;
      m_rstb = 1'b0;
      @(negedge clk);
      total++;
      if (m_crstb !== 4'b0000) begin bad++; $display("FAIL drop_second: got %b want 0000", m_crstb); end
      wait_rvalid(n, d);
      total++;
      if (n + 2 !== RD_LAT + 2) begin bad++; $display("FAIL drop_latency: got %0d want %0d", n + 2, RD_LAT + 2); end
      exp = (mq.size() > 0) ? mq.pop_front() : 32'h0;
      total++;
      if (d !== exp) begin bad++; $display("FAIL drop_data: got %h want %h", d, exp); end
      total++;
      if (m_drop !== 8'd1) begin bad++; $display("FAIL drop_count: got %0d want 1", m_drop); end
      @(posedge clk); #1;
      drive(24'h000020, 32'h0000_ABCD, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      total++;
      if ({m_cwstb, m_crstb, m_cwe} !== {4'b0001, 4'b0000, 1'b1}) begin
         bad++; $display("FAIL wr_rd_same: got %h want %h", {m_cwstb, m_crstb, m_cwe}, {4'b0001, 4'b0, 1'b1});
      end
      wait_rvalid(n, d);
      total++;
      if (n !== 0) begin bad++; $display("FAIL wr_rd_no_rvalid: got cycle %0d want none", n); end
      total++;
      if (m_drop !== 8'd2) begin bad++; $display("FAIL wr_rd_drop: got %0d want 2", m_drop); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int n;
      logic [31:0] d, exp;
      m_din[0 +: 32] = 32'h0000_AAAA;
      mq.push_back(32'h0000_AAAA);
      m_addr = 24'h000008; m_rstb = 1'b1;
      @(posedge clk); #1;
      m_rstb = 1'b0; m_addr = 24'h100040; m_dout = 32'h55; m_we = 1'b1; m_wstb = 1'b1;
      @(negedge clk);
      total++;
      if (m_crstb !== 4'b0001) begin bad++; $display("FAIL b2b_rstb: got %b want 0001", m_crstb); end
      @(posedge clk); #1;
      m_we = 1'b0; m_wstb = 1'b0;
      @(negedge clk);
      total++;
      if ({m_cwstb, m_caddr} !== {4'b0010, 20'h00040}) begin
         bad++; $display("FAIL b2b_write: got %h want %h", {m_cwstb, m_caddr}, {4'b0010, 20'h40});
      end
      wait_rvalid(n, d);
      total++;
      if (n + 2 !== RD_LAT + 2) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", n + 2, RD_LAT + 2); end
      exp = (mq.size() > 0) ? mq.pop_front() : 32'h0;
      total++;
      if (d !== exp) begin bad++; $display("FAIL b2b_data: got %h want %h", d, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      int stray = 0;
      m_we = 1'b1; m_wstb = 1'b1;
      for (int i = 0; i < 300; i++) begin
         m_addr = 24'h800000 | 24'(i);
         @(negedge clk);
         if (m_cwstb !== 4'b0000) stray++;
         @(posedge clk); #1;
      end
      m_we = 1'b0; m_wstb = 1'b0;
      @(negedge clk);
      total++;
      if (stray !== 0) begin bad++; $display("FAIL sat_no_strobe: got %0d strobes want 0", stray); end
      total++;
      if ({m_unmap, m_drop} !== {8'hFF, 8'd2}) begin
         bad++; $display("FAIL sat_counters: got %h want FF02", {m_unmap, m_drop});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_read();
      int n;
      logic [31:0] d;
      drive(24'h300000, 32'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      total++;
      if ({m_gdin, m_rvalid, m_caddr, m_cdout, m_cwe, m_cwstb, m_crstb, m_unmap, m_drop} !== '0) begin
         bad++; $display("FAIL rst_mid_outputs: got %h want 0",
                         {m_gdin, m_rvalid, m_caddr, m_cdout, m_cwe, m_cwstb, m_crstb, m_unmap, m_drop});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      wait_rvalid(n, d);
      total++;
      if (n !== 0 || m_gdin !== 32'h0) begin
         bad++; $display("FAIL rst_mid_no_rvalid: got cycle %0d din %h want none/0", n, m_gdin);
      end
      total++;
      if (mq.size() !== 0) begin bad++; $display("FAIL main_queue_left: got %0d want 0", mq.size()); end
      @(posedge clk); #1;
   endtask

   task automatic test_random_sweep();
      logic [7:0]  unm[3] = '{8'd0, 8'd0, 8'd0};
      logic [15:0] exp_oh[3];
      int nib, cb, ch, is_rd, idx;
      logic hit;
      for (int i = 0; i < 16; i++) s16_din[i*32 +: 32] = chdata(2, i);
      for (int i = 0; i < 3; i++)  s3_din[i*32 +: 32]  = chdata(1, i);
      s1_din = chdata(0, 0);
      for (int t = 0; t < 40; t++) begin
         nib   = int'($urandom_range(0, 15));
         is_rd = int'($urandom_range(0, 1));
         s_addr = {4'(nib), 20'($urandom)};
         s_dout = $urandom;
         s_we = (is_rd == 0); s_wstb = (is_rd == 0); s_rstb = (is_rd != 0);
         for (int d = 0; d < 3; d++) begin
            cb  = (nch_of(d) == 1) ? 0 : $clog2(nch_of(d));
            ch  = nib % (1 << cb);
            hit = ((nib >> cb) == 0) && (ch < nch_of(d));
            exp_oh[d] = hit ? 16'(1 << ch) : 16'h0;
            if (!hit && unm[d] != 8'hFF) unm[d] = unm[d] + 8'd1;
            if (is_rd != 0) sq.push_back('{d, hit ? chdata(d, ch) : 32'hDEADBEEF});
         end
         @(posedge clk); #1;
         s_we = 1'b0; s_wstb = 1'b0; s_rstb = 1'b0;
         for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
               if (k == 1) begin
                  total++;
                  if ({sw_wstb[d], sw_rstb[d]} !== (is_rd != 0 ? {16'h0, exp_oh[d]} : {exp_oh[d], 16'h0})) begin
                     bad++; $display("FAIL sweep_strobe n%0d t%0d: got %h_%h want oh %h rd %0d",
                                     nch_of(d), t, sw_wstb[d], sw_rstb[d], exp_oh[d], is_rd);
                  end
               end
               if (sw_rv[d]) begin
                  idx = -1;
                  for (int q = 0; q < sq.size(); q++) if (idx < 0 && sq[q].d == d) idx = q;
                  total++;
                  if (idx < 0) begin
                     bad++; $display("FAIL sweep_unexpected n%0d t%0d: got rvalid want none", nch_of(d), t);
                  end else begin
                     if (sw_gdin[d] !== sq[idx].data || k !== lat_of(d) + 2) begin
                        bad++; $display("FAIL sweep_read n%0d t%0d: got %h @%0d want %h @%0d",
                                        nch_of(d), t, sw_gdin[d], k, sq[idx].data, lat_of(d) + 2);
                     end
                     sq.delete(idx);
                  end
               end
            end
         end
         total++;
         if (sq.size() !== 0) begin
            bad++; $display("FAIL sweep_missing t%0d: got %0d pending want 0", t, sq.size());
            sq.delete();
         end
         for (int d = 0; d < 3; d++) begin
            total++;
            if (sw_unmap[d] !== unm[d]) begin
               bad++; $display("FAIL sweep_unmap n%0d t%0d: got %0d want %0d", nch_of(d), t, sw_unmap[d], unm[d]);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_unmapped();
      test_drop();
      test_back_to_back();
      test_saturate();
      test_reset_mid_read();
      test_random_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
